// File: rtl/udp_tx_sched.sv
//------------------------------------------------------------------------------
// Module   : udp_tx_sched
// Brief    : HDMI-over-UDP transmit scheduler; arbitrates video segments and
//            aux chunks, issues one packet descriptor per frame to the builder.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module udp_tx_sched #(
    parameter logic [3:0]  MAX_AUX = 4'd8,
    parameter logic [15:0] STARVE  = 16'd20000,
    parameter logic [7:0]  IFG     = 8'd12,
    parameter logic [15:0] TX_TMO  = 16'd4000
) (
    input  logic        clk125,
    input  logic        sys_rst,
    input  logic        en,
    input  logic        vid_rdy,
    input  logic [11:0] vid_y,
    input  logic [3:0]  vid_x,
    input  logic [7:0]  aux_cnt,
    output logic        pkt_valid,
    input  logic        pkt_ready,
    output logic [7:0]  pkt_info,
    output logic [11:0] pkt_y,
    output logic [3:0]  pkt_x,
    input  logic        tx_done,
    output logic        vid_ack,
    output logic        aux_take_en,
    output logic [3:0]  aux_take,
    output logic        busy,
    output logic        err_tmo
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_OFFER = 2'd1;
    localparam logic [1:0] c_ST_BUSY  = 2'd2;
    localparam logic [1:0] c_ST_GAP   = 2'd3;

    localparam logic [3:0] c_TYPE_VIDEO = 4'h0;
    localparam logic [3:0] c_TYPE_AUDIO = 4'h1;
    localparam logic [3:0] c_TYPE_VIDAX = 4'h2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [7:0]  r_info;
    logic [11:0] r_y;
    logic [3:0]  r_x;
    logic [15:0] r_tmo;
    logic [7:0]  r_gap;
    logic        r_err;
    logic [15:0] r_starve;

    logic        w_aux_nz;
    logic [7:0]  w_aux_min;
    logic [3:0]  w_adenum;
    logic        w_aux_due;
    logic        w_go;
    logic        w_accept;
    logic        w_tmo_hit;
    logic        w_busy_end;
    logic        w_take_en;
    logic [7:0]  w_dec_info;
    logic [11:0] w_dec_y;
    logic [3:0]  w_dec_x;

    // min() is done at full 8-bit width so large queue depths clamp to MAX_AUX
    assign w_aux_nz   = (aux_cnt != 8'd0);
    assign w_aux_min  = (aux_cnt < {4'd0, MAX_AUX}) ? aux_cnt : {4'd0, MAX_AUX};
    assign w_adenum   = w_aux_min[3:0];
    assign w_aux_due  = w_aux_nz && ((r_starve >= STARVE) || (aux_cnt >= {4'd0, MAX_AUX}));
    assign w_go       = en && (vid_rdy || w_aux_due);
    assign w_accept   = (r_state == c_ST_OFFER) && pkt_ready;
    assign w_tmo_hit  = (r_tmo == (TX_TMO - 16'd1));
    assign w_busy_end = (r_state == c_ST_BUSY) && (tx_done || w_tmo_hit);
    assign w_take_en  = w_accept && (r_info[7:4] != 4'd0);

    always_comb begin
        w_dec_info = {w_adenum, c_TYPE_AUDIO};
        w_dec_y    = 12'd0;
        w_dec_x    = 4'd0;
        if (vid_rdy) begin
            w_dec_info = w_aux_nz ? {w_adenum, c_TYPE_VIDAX} : {4'd0, c_TYPE_VIDEO};
            w_dec_y    = vid_y;
            w_dec_x    = vid_x;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  if (w_go)         w_state_nxt = c_ST_OFFER;
            c_ST_OFFER: if (pkt_ready)    w_state_nxt = c_ST_BUSY;
            c_ST_BUSY:  if (w_busy_end)   w_state_nxt = c_ST_GAP;
            c_ST_GAP:   if (r_gap == 8'd0) w_state_nxt = c_ST_IDLE;
            default:                      w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk125) begin
        if (sys_rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk125) begin
        if (sys_rst) begin
            r_info   <= 8'd0;
            r_y      <= 12'd0;
            r_x      <= 4'd0;
            r_tmo    <= 16'd0;
            r_gap    <= 8'd0;
            r_err    <= 1'b0;
            r_starve <= 16'd0;
        end else begin
            if ((r_state == c_ST_IDLE) && w_go) begin
                r_info <= w_dec_info;
                r_y    <= w_dec_y;
                r_x    <= w_dec_x;
            end

            if (w_accept) begin
                r_tmo <= 16'd0;
            end else if ((r_state == c_ST_BUSY) && !w_busy_end) begin
                r_tmo <= r_tmo + 16'd1;
            end

            // a tx_done arriving on the expiry cycle still counts as success
            if ((r_state == c_ST_BUSY) && !tx_done && w_tmo_hit) begin
                r_err <= 1'b1;
            end

            if (w_busy_end) begin
                r_gap <= IFG;
            end else if ((r_state == c_ST_GAP) && (r_gap != 8'd0)) begin
                r_gap <= r_gap - 8'd1;
            end

            if (!w_aux_nz || w_take_en) begin
                r_starve <= 16'd0;
            end else if (r_starve != 16'hFFFF) begin
                r_starve <= r_starve + 16'd1;
            end
        end
    end

    assign pkt_valid   = (r_state == c_ST_OFFER);
    assign pkt_info    = r_info;
    assign pkt_y       = r_y;
    assign pkt_x       = r_x;
    assign vid_ack     = w_accept && (r_info[3:0] != c_TYPE_AUDIO);
    assign aux_take_en = w_take_en;
    assign aux_take    = w_take_en ? r_info[7:4] : 4'd0;
    assign busy        = (r_state != c_ST_IDLE);
    assign err_tmo     = r_err;

endmodule

`default_nettype wire
